bp_nonsynth_commit_packer: RTL and testbench
============================================

BP_NONSYNTH_COMMIT_PACKER -- requirements
Module: bp_nonsynth_commit_packer

Interface
REQ-001 Params: vaddr_width_p, 39, PC width; instr_width_p, 32, instruction width; dword_width_p, 64, data/cause width; els_p, 8, record buffer depth (power of 2, >=2).
REQ-002 clk_i  in  1  sole clock; all state on posedge.
REQ-003 reset_n_i  in  1  reset, asynchronous and active-low.
REQ-004 commit_v_i  in  1  instruction retires this cycle.
REQ-005 commit_pc_i / commit_instr_i  in  vaddr_width_p / instr_width_p  retiring PC and encoding.
REQ-006 commit_rd_w_v_i  in  1  retiring instruction owes an integer rd writeback.
REQ-007 commit_rd_addr_i  in  5  destination register.
REQ-008 trap_v_i  in  1  trap/interrupt taken this cycle; cause_i  in  dword_width_p  its cause.
REQ-009 wb_v_i / wb_addr_i / wb_data_i  in  1 / 5 / dword_width_p  integer regfile writeback, in program order.
REQ-010 pkt_v_o  out  1  record valid; pkt_yumi_i  in  1  consumer accepts (only while pkt_v_o=1).
REQ-011 pkt_pc_o, pkt_instr_o, pkt_rd_w_v_o, pkt_rd_addr_o, pkt_rd_data_o, pkt_trap_v_o, pkt_cause_o  out  field widths  head record.
REQ-012 full_o  out  1  buffer holds els_p records.
REQ-013 err_o  out  2  sticky: [0] overflow, [1] orphan/mismatched writeback.

Function
REQ-014 Circular buffer of els_p records {pc, instr, rd_w_v, rd_addr, rd_data, trap_v, cause, filled}; rd/wr pointers wrap modulo els_p; count 0..els_p.
REQ-015 Enqueue when (commit_v_i | trap_v_i) & ~full_o; one record per cycle.
REQ-016 trap_v_i=1: record trap_v=1, cause=cause_i, rd_w_v=0, filled=1; simultaneous commit_v_i folded into same record (pc/instr captured).
REQ-017 commit_rd_w_v_i with commit_rd_addr_i=0: rd_w_v stored 0, filled=1.
REQ-018 Non-trap record with rd_w_v=0: filled=1 at enqueue, rd_data=0.
REQ-019 Writeback targets oldest in-buffer record with rd_w_v=1 & filled=0; writes rd_data, sets filled.
REQ-020 Same-cycle bypass: no such buffered record and enqueuing record owes writeback -> wb fills enqueuing record that cycle.
REQ-021 wb_v_i with no target, or wb_addr_i != target rd_addr: set err_o[1]; data dropped, target unchanged.
REQ-022 Enqueue attempt while full_o=1 (without same-cycle dequeue): record dropped, err_o[0] set.
REQ-023 Enqueue and dequeue same cycle while full: both proceed, count unchanged, no error.
REQ-024 pkt_v_o = (count!=0) & head.filled; outputs driven from head entry, valid from cycle after enqueue/fill (latency 1 for filled-at-enqueue records).
REQ-025 pkt_yumi_i: advance read pointer, decrement count; pkt_yumi_i while pkt_v_o=0 ignored.
REQ-026 Records leave strictly in enqueue order; unfilled head blocks younger filled records.
REQ-027 err_o bits remain set until reset.

Reset
REQ-028 reset_n_i low: pointers, count, filled flags, err_o cleared immediately; pkt_v_o=0, full_o=0, all pkt fields 0.
REQ-029 Reset asserted mid-operation discards all buffered records; no record emitted until new enqueue after deassertion.

Verification
REQ-030 Commit pc=0x80000000, rd_w_v=0, yumi held 1 -> pkt_v_o next cycle, rd_data 0, one cycle.
REQ-031 Commit rd=x5 at cycle 0, wb x5=0xDEAD at cycle 3 -> pkt_v_o first at cycle 4, rd_data 0xDEAD; younger no-wb commit at cycle 1 emitted only after it.
REQ-032 Commit rd=x7 with wb x7=0x1234 same cycle, buffer empty -> pkt_v_o next cycle, rd_data 0x1234, err_o=0.
REQ-033 Nine commits, yumi=0, els_p=8 -> full_o=1 after 8th, err_o[0]=1, 8 records drain in order, 9th absent.
REQ-034 trap_v_i with cause 0x8000000000000007 plus commit_v_i -> single record trap_v=1, rd_w_v=0; stray wb x3 with empty buffer -> err_o[1]=1.
REQ-035 Reset asserted with 3 records held -> pkt_v_o=0 asynchronously, count 0, err_o=0 after release.

Source files
------------

// File: rtl/bp_nonsynth_commit_packer_if.sv
// Commit/trap/writeback inputs and the packed-record output stream of
// the commit packer, grouped so producer and consumer share one bundle.
interface bp_nonsynth_commit_packer_if
    #(parameter int vaddr_width_p = 39
    , parameter int instr_width_p = 32
    , parameter int dword_width_p = 64
    );

    // Retirement side
    logic                     commit_v_i;
    logic [vaddr_width_p-1:0] commit_pc_i;
    logic [instr_width_p-1:0] commit_instr_i;
    logic                     commit_rd_w_v_i;
    logic [4:0]               commit_rd_addr_i;

    // Trap side
    logic                     trap_v_i;
    logic [dword_width_p-1:0] cause_i;

    // Integer regfile writeback, in program order
    logic                     wb_v_i;
    logic [4:0]               wb_addr_i;
    logic [dword_width_p-1:0] wb_data_i;

    // Head record stream
    logic                     pkt_v_o;
    logic                     pkt_yumi_i;
    logic [vaddr_width_p-1:0] pkt_pc_o;
    logic [instr_width_p-1:0] pkt_instr_o;
    logic                     pkt_rd_w_v_o;
    logic [4:0]               pkt_rd_addr_o;
    logic [dword_width_p-1:0] pkt_rd_data_o;
    logic                     pkt_trap_v_o;
    logic [dword_width_p-1:0] pkt_cause_o;

    // Status
    logic                     full_o;
    logic [1:0]               err_o;

    // The side that drives retirement info and consumes records
    modport master (
        output commit_v_i, commit_pc_i, commit_instr_i, commit_rd_w_v_i, commit_rd_addr_i,
        output trap_v_i, cause_i,
        output wb_v_i, wb_addr_i, wb_data_i,
        output pkt_yumi_i,
        input  pkt_v_o, pkt_pc_o, pkt_instr_o, pkt_rd_w_v_o, pkt_rd_addr_o,
        input  pkt_rd_data_o, pkt_trap_v_o, pkt_cause_o,
        input  full_o, err_o
    );

    // The packer itself
    modport slave (
        input  commit_v_i, commit_pc_i, commit_instr_i, commit_rd_w_v_i, commit_rd_addr_i,
        input  trap_v_i, cause_i,
        input  wb_v_i, wb_addr_i, wb_data_i,
        input  pkt_yumi_i,
        output pkt_v_o, pkt_pc_o, pkt_instr_o, pkt_rd_w_v_o, pkt_rd_addr_o,
        output pkt_rd_data_o, pkt_trap_v_o, pkt_cause_o,
        output full_o, err_o
    );

endinterface

// File: rtl/bp_nonsynth_commit_packer.sv
// Commit packer: buffers retiring instructions in order, merges each one
// with its later integer writeback, and emits complete records in program
// order. Records that owe a writeback block the head until it arrives.
module bp_nonsynth_commit_packer
    #(parameter int vaddr_width_p = 39
    , parameter int instr_width_p = 32
    , parameter int dword_width_p = 64
    , parameter int els_p         = 8
    )
    (input logic clk_i
    , input logic reset_n_i
    , bp_nonsynth_commit_packer_if.slave bus
    );

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = ptr_w + 1;

    logic [vaddr_width_p-1:0] pc_r      [els_p];
    logic [instr_width_p-1:0] instr_r   [els_p];
    logic                     rd_w_v_r  [els_p];
    logic [4:0]               rd_addr_r [els_p];
    logic [dword_width_p-1:0] rd_data_r [els_p];
    logic                     trap_v_r  [els_p];
    logic [dword_width_p-1:0] cause_r   [els_p];
    logic                     filled_r  [els_p];

    logic [ptr_w-1:0] rd_ptr_r, wr_ptr_r;
    logic [cnt_w-1:0] count_r;
    logic [1:0]       err_r;

    logic             full;
    logic             deq;
    logic             enq_attempt;
    logic             enq;
    logic             enq_rd_w_v;
    logic             bypass;
    logic             enq_filled;
    logic             target_found;
    logic [ptr_w-1:0] target_idx;
    logic [ptr_w-1:0] scan_idx;
    logic             wb_to_target;
    logic             wb_err;
    logic             ovf_err;

    assign full        = (count_r == cnt_w'(els_p));
    assign bus.pkt_v_o = (count_r != '0) & filled_r[rd_ptr_r];
    assign deq         = bus.pkt_yumi_i & bus.pkt_v_o;
    assign enq_attempt = bus.commit_v_i | bus.trap_v_i;
    assign enq         = enq_attempt & (~full | deq);
    assign ovf_err     = enq_attempt & full & ~deq;

    // A writeback to x0 is never observable, so such records complete at enqueue
    assign enq_rd_w_v  = ~bus.trap_v_i & bus.commit_v_i & bus.commit_rd_w_v_i
                       & (bus.commit_rd_addr_i != 5'd0);

    // Locate the oldest buffered record still waiting for its writeback
    always_comb begin
        target_found = 1'b0;
        target_idx   = '0;
        scan_idx     = '0;
        for (int i = 0; i < els_p; i++) begin
            scan_idx = rd_ptr_r + ptr_w'(i);
            if (!target_found && (cnt_w'(i) < count_r)
                && rd_w_v_r[scan_idx] && !filled_r[scan_idx]) begin
                target_found = 1'b1;
                target_idx   = scan_idx;
            end
        end
    end

    // Route the writeback to a buffered record, the entering record, or flag it
    assign wb_to_target = bus.wb_v_i & target_found & (bus.wb_addr_i == rd_addr_r[target_idx]);
    assign bypass       = bus.wb_v_i & ~target_found & enq & enq_rd_w_v
                        & (bus.wb_addr_i == bus.commit_rd_addr_i);
    assign wb_err       = bus.wb_v_i & ~wb_to_target & ~bypass;
    assign enq_filled   = ~enq_rd_w_v | bypass;

    // Buffer storage, pointers, occupancy and sticky error flags
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            err_r    <= '0;
            for (int i = 0; i < els_p; i++) begin
                pc_r[i]      <= '0;
                instr_r[i]   <= '0;
                rd_w_v_r[i]  <= 1'b0;
                rd_addr_r[i] <= '0;
                rd_data_r[i] <= '0;
                trap_v_r[i]  <= 1'b0;
                cause_r[i]   <= '0;
                filled_r[i]  <= 1'b0;
            end
        end else begin
            if (enq) begin
                pc_r[wr_ptr_r]      <= bus.commit_v_i ? bus.commit_pc_i : '0;
                instr_r[wr_ptr_r]   <= bus.commit_v_i ? bus.commit_instr_i : '0;
                rd_w_v_r[wr_ptr_r]  <= enq_rd_w_v;
                rd_addr_r[wr_ptr_r] <= bus.commit_v_i ? bus.commit_rd_addr_i : 5'd0;
                rd_data_r[wr_ptr_r] <= bypass ? bus.wb_data_i : '0;
                trap_v_r[wr_ptr_r]  <= bus.trap_v_i;
                cause_r[wr_ptr_r]   <= bus.trap_v_i ? bus.cause_i : '0;
                filled_r[wr_ptr_r]  <= enq_filled;
                wr_ptr_r            <= wr_ptr_r + 1'b1;
            end
            if (wb_to_target) begin
                rd_data_r[target_idx] <= bus.wb_data_i;
                filled_r[target_idx]  <= 1'b1;
            end
            if (deq) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_r + cnt_w'(enq) - cnt_w'(deq);
            err_r   <= err_r | {wb_err, ovf_err};
        end
    end

    assign bus.full_o        = full;
    assign bus.err_o         = err_r;
    assign bus.pkt_pc_o      = pc_r[rd_ptr_r];
    assign bus.pkt_instr_o   = instr_r[rd_ptr_r];
    assign bus.pkt_rd_w_v_o  = rd_w_v_r[rd_ptr_r];
    assign bus.pkt_rd_addr_o = rd_addr_r[rd_ptr_r];
    assign bus.pkt_rd_data_o = rd_data_r[rd_ptr_r];
    assign bus.pkt_trap_v_o  = trap_v_r[rd_ptr_r];
    assign bus.pkt_cause_o   = cause_r[rd_ptr_r];

endmodule

// File: tb/tb_bp_nonsynth_commit_packer.sv
// Directed bench for the commit packer: each task drives one scenario and
// checks the head record against hand-computed values.
module tb_bp_nonsynth_commit_packer;

    logic clk_i;
    logic reset_n_i;
    int   checks;
    int   failures;

    bp_nonsynth_commit_packer_if bus ();

    bp_nonsynth_commit_packer dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one edge and settle just past it
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.commit_v_i       = 1'b0;
        bus.commit_pc_i      = '0;
        bus.commit_instr_i   = '0;
        bus.commit_rd_w_v_i  = 1'b0;
        bus.commit_rd_addr_i = '0;
        bus.trap_v_i         = 1'b0;
        bus.cause_i          = '0;
        bus.wb_v_i           = 1'b0;
        bus.wb_addr_i        = '0;
        bus.wb_data_i        = '0;
        bus.pkt_yumi_i       = 1'b0;
    endtask

    task automatic commit(input logic [38:0] pc, input logic rd_w_v, input logic [4:0] rd);
        bus.commit_v_i       = 1'b1;
        bus.commit_pc_i      = pc;
        bus.commit_instr_i   = 32'h0000_0013;
        bus.commit_rd_w_v_i  = rd_w_v;
        bus.commit_rd_addr_i = rd;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n_i = 1'b0;
        #3;
        reset_n_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n_i = 1'b0;
        #7;
        checks++;
        if (bus.pkt_v_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_pkt_v got=%0b want=0", bus.pkt_v_o);
        end
        checks++;
        if (bus.full_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_full got=%0b want=0", bus.full_o);
        end
        checks++;
        if (bus.err_o !== 2'b00) begin
            failures++; $display("[TB] FAIL reset_err got=%0b want=00", bus.err_o);
        end
        checks++;
        if (bus.pkt_pc_o !== 39'h0 || bus.pkt_rd_data_o !== 64'h0) begin
            failures++; $display("[TB] FAIL reset_fields got pc=%h data=%h want 0", bus.pkt_pc_o, bus.pkt_rd_data_o);
        end
        reset_n_i = 1'b1;
        tick();
    endtask

    task automatic test_no_wb();
        bus.pkt_yumi_i = 1'b1;
        commit(39'h80000000, 1'b0, 5'd0);
        tick();
        bus.commit_v_i = 1'b0;
        checks++;
        if (bus.pkt_v_o !== 1'b1 || bus.pkt_pc_o !== 39'h80000000 || bus.pkt_rd_data_o !== 64'h0) begin
            failures++;
            $display("[TB] FAIL no_wb_pkt got v=%0b pc=%h data=%h want v=1 pc=80000000 data=0",
                     bus.pkt_v_o, bus.pkt_pc_o, bus.pkt_rd_data_o);
        end
        tick();
        checks++;
        if (bus.pkt_v_o !== 1'b0) begin
            failures++; $display("[TB] FAIL no_wb_one_cycle got v=%0b want=0", bus.pkt_v_o);
        end
        idle_inputs();
    endtask

    task automatic test_late_wb();
        commit(39'h100, 1'b1, 5'd5);
        tick();
        commit(39'h104, 1'b0, 5'd0);
        tick();
        idle_inputs();
        checks++;
        if (bus.pkt_v_o !== 1'b0) begin
            failures++; $display("[TB] FAIL late_wb_blocked_c2 got v=%0b want=0", bus.pkt_v_o);
        end
        tick();
        checks++;
        if (bus.pkt_v_o !== 1'b0) begin
            failures++; $display("[TB] FAIL late_wb_blocked_c3 got v=%0b want=0", bus.pkt_v_o);
        end
        bus.wb_v_i    = 1'b1;
        bus.wb_addr_i = 5'd5;
        bus.wb_data_i = 64'hDEAD;
        tick();
        idle_inputs();
        checks++;
        if (bus.pkt_v_o !== 1'b1 || bus.pkt_pc_o !== 39'h100 || bus.pkt_rd_data_o !== 64'hDEAD) begin
            failures++;
            $display("[TB] FAIL late_wb_head got v=%0b pc=%h data=%h want v=1 pc=100 data=dead",
                     bus.pkt_v_o, bus.pkt_pc_o, bus.pkt_rd_data_o);
        end
        bus.pkt_yumi_i = 1'b1;
        tick();
        checks++;
        if (bus.pkt_v_o !== 1'b1 || bus.pkt_pc_o !== 39'h104 || bus.pkt_rd_data_o !== 64'h0) begin
            failures++;
            $display("[TB] FAIL late_wb_younger got v=%0b pc=%h data=%h want v=1 pc=104 data=0",
                     bus.pkt_v_o, bus.pkt_pc_o, bus.pkt_rd_data_o);
        end
        tick();
        bus.pkt_yumi_i = 1'b0;
        checks++;
        if (bus.pkt_v_o !== 1'b0 || bus.err_o !== 2'b00) begin
            failures++; $display("[TB] FAIL late_wb_drained got v=%0b err=%0b want v=0 err=00", bus.pkt_v_o, bus.err_o);
        end
    endtask

    task automatic test_bypass();
        commit(39'h200, 1'b1, 5'd7);
        bus.wb_v_i    = 1'b1;
        bus.wb_addr_i = 5'd7;
        bus.wb_data_i = 64'h1234;
        tick();
        idle_inputs();
        checks++;
        if (bus.pkt_v_o !== 1'b1 || bus.pkt_rd_data_o !== 64'h1234 || bus.pkt_rd_w_v_o !== 1'b1
            || bus.pkt_rd_addr_o !== 5'd7 || bus.err_o !== 2'b00) begin
            failures++;
            $display("[TB] FAIL bypass got v=%0b data=%h wv=%0b rd=%0d err=%0b want v=1 data=1234 wv=1 rd=7 err=00",
                     bus.pkt_v_o, bus.pkt_rd_data_o, bus.pkt_rd_w_v_o, bus.pkt_rd_addr_o, bus.err_o);
        end
        bus.pkt_yumi_i = 1'b1;
        tick();
        bus.pkt_yumi_i = 1'b0;
    endtask

    task automatic test_x0_dest();
        commit(39'h240, 1'b1, 5'd0);
        tick();
        idle_inputs();
        checks++;
        if (bus.pkt_v_o !== 1'b1 || bus.pkt_rd_w_v_o !== 1'b0 || bus.pkt_rd_data_o !== 64'h0) begin
            failures++;
            $display("[TB] FAIL x0_dest got v=%0b wv=%0b data=%h want v=1 wv=0 data=0",
                     bus.pkt_v_o, bus.pkt_rd_w_v_o, bus.pkt_rd_data_o);
        end
        bus.pkt_yumi_i = 1'b1;
        tick();
        bus.pkt_yumi_i = 1'b0;
    endtask

    task automatic test_trap();
        commit(39'h300, 1'b1, 5'd4);
        bus.trap_v_i = 1'b1;
        bus.cause_i  = 64'h8000000000000007;
        tick();
        idle_inputs();
        checks++;
        if (bus.pkt_v_o !== 1'b1 || bus.pkt_trap_v_o !== 1'b1 || bus.pkt_rd_w_v_o !== 1'b0
            || bus.pkt_cause_o !== 64'h8000000000000007 || bus.pkt_pc_o !== 39'h300) begin
            failures++;
            $display("[TB] FAIL trap_rec got v=%0b trap=%0b wv=%0b cause=%h pc=%h want v=1 trap=1 wv=0 cause=8000000000000007 pc=300",
                     bus.pkt_v_o, bus.pkt_trap_v_o, bus.pkt_rd_w_v_o, bus.pkt_cause_o, bus.pkt_pc_o);
        end
        bus.pkt_yumi_i = 1'b1;
        tick();
        bus.pkt_yumi_i = 1'b0;
        checks++;
        if (bus.pkt_v_o !== 1'b0) begin
            failures++; $display("[TB] FAIL trap_single got v=%0b want=0", bus.pkt_v_o);
        end
        bus.wb_v_i    = 1'b1;
        bus.wb_addr_i = 5'd3;
        bus.wb_data_i = 64'h33;
        tick();
        idle_inputs();
        checks++;
        if (bus.err_o !== 2'b10) begin
            failures++; $display("[TB] FAIL stray_wb_err got=%0b want=10", bus.err_o);
        end
    endtask

    task automatic test_mismatch_wb();
        apply_reset();
        commit(39'h400, 1'b1, 5'd5);
        tick();
        idle_inputs();
        bus.wb_v_i    = 1'b1;
        bus.wb_addr_i = 5'd9;
        bus.wb_data_i = 64'hFF;
        tick();
        idle_inputs();
        checks++;
        if (bus.err_o !== 2'b10 || bus.pkt_v_o !== 1'b0) begin
            failures++; $display("[TB] FAIL mismatch_wb got err=%0b v=%0b want err=10 v=0", bus.err_o, bus.pkt_v_o);
        end
        bus.wb_v_i    = 1'b1;
        bus.wb_addr_i = 5'd5;
        bus.wb_data_i = 64'h55;
        tick();
        idle_inputs();
        checks++;
        if (bus.pkt_v_o !== 1'b1 || bus.pkt_rd_data_o !== 64'h55) begin
            failures++; $display("[TB] FAIL mismatch_recover got v=%0b data=%h want v=1 data=55", bus.pkt_v_o, bus.pkt_rd_data_o);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            commit(39'h1000 + 39'(4 * i), 1'b0, 5'd0);
            tick();
        end
        checks++;
        if (bus.full_o !== 1'b1 || bus.err_o !== 2'b00) begin
            failures++; $display("[TB] FAIL full_after_8 got full=%0b err=%0b want full=1 err=00", bus.full_o, bus.err_o);
        end
        commit(39'h1020, 1'b0, 5'd0);
        tick();
        idle_inputs();
        checks++;
        if (bus.err_o !== 2'b01 || bus.full_o !== 1'b1) begin
            failures++; $display("[TB] FAIL overflow_err got err=%0b full=%0b want err=01 full=1", bus.err_o, bus.full_o);
        end
        bus.pkt_yumi_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.pkt_v_o !== 1'b1 || bus.pkt_pc_o !== 39'h1000 + 39'(4 * i)) begin
                failures++;
                $display("[TB] FAIL drain_%0d got v=%0b pc=%h want v=1 pc=%h",
                         i, bus.pkt_v_o, bus.pkt_pc_o, 39'h1000 + 39'(4 * i));
            end
            tick();
        end
        bus.pkt_yumi_i = 1'b0;
        checks++;
        if (bus.pkt_v_o !== 1'b0 || bus.full_o !== 1'b0) begin
            failures++; $display("[TB] FAIL ninth_absent got v=%0b full=%0b want v=0 full=0", bus.pkt_v_o, bus.full_o);
        end
    endtask

    task automatic test_full_enq_deq();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            commit(39'h3000 + 39'(4 * i), 1'b0, 5'd0);
            tick();
        end
        commit(39'h2000, 1'b0, 5'd0);
        bus.pkt_yumi_i = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.full_o !== 1'b1 || bus.err_o !== 2'b00 || bus.pkt_pc_o !== 39'h3004) begin
            failures++;
            $display("[TB] FAIL full_enq_deq got full=%0b err=%0b pc=%h want full=1 err=00 pc=3004",
                     bus.full_o, bus.err_o, bus.pkt_pc_o);
        end
        bus.pkt_yumi_i = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (bus.pkt_v_o !== 1'b1 || bus.pkt_pc_o !== 39'h2000) begin
            failures++; $display("[TB] FAIL full_enq_deq_tail got v=%0b pc=%h want v=1 pc=2000", bus.pkt_v_o, bus.pkt_pc_o);
        end
        tick();
        bus.pkt_yumi_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            commit(39'h500 + 39'(4 * i), 1'b0, 5'd0);
            tick();
        end
        idle_inputs();
        bus.wb_v_i    = 1'b1;
        bus.wb_addr_i = 5'd1;
        tick();
        idle_inputs();
        checks++;
        if (bus.pkt_v_o !== 1'b1 || bus.err_o !== 2'b10) begin
            failures++; $display("[TB] FAIL pre_reset_held got v=%0b err=%0b want v=1 err=10", bus.pkt_v_o, bus.err_o);
        end
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (bus.pkt_v_o !== 1'b0 || bus.full_o !== 1'b0 || bus.pkt_pc_o !== 39'h0) begin
            failures++; $display("[TB] FAIL async_reset got v=%0b full=%0b pc=%h want 0", bus.pkt_v_o, bus.full_o, bus.pkt_pc_o);
        end
        #3;
        reset_n_i = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.pkt_v_o !== 1'b0 || bus.err_o !== 2'b00) begin
            failures++; $display("[TB] FAIL post_reset got v=%0b err=%0b want v=0 err=00", bus.pkt_v_o, bus.err_o);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_no_wb();
        test_late_wb();
        test_bypass();
        test_x0_dest();
        test_trap();
        test_mismatch_wb();
        test_overflow();
        test_full_enq_deq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
